// File: rtl/w5300_bus_timer_pkg.sv
// Shared definitions for the W5300 bus-cycle sequencer: the FSM state
// encoding, the default phase timings and a small state-classification helper.
package w5300_bus_pkg;

    // Default phase lengths in clk cycles (each must be >= 1).
    localparam int SETUP_CYC_DEF   = 1;
    localparam int STROBE_CYC_DEF  = 3;
    localparam int RECOVER_CYC_DEF = 2;

    // Default width of the shared phase counter.
    localparam int CNT_W_DEF       = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        ACK     = 3'd3,
        RECOVER = 3'd4
    } bus_state_t;

    // True in the states where the W5300 chip select is driven low.
    function automatic logic cs_phase(input bus_state_t s);
        return (s == SETUP) || (s == STROBE) || (s == ACK);
    endfunction

    // True in the states where the read or write strobe is driven low.
    function automatic logic strobe_phase(input bus_state_t s);
        return (s == STROBE) || (s == ACK);
    endfunction

endpackage

// File: rtl/w5300_bus_timer_if.sv
// Signal bundle between the 68008 host/decoder side and the W5300 strobe
// generator. The timer uses the slave view; whatever drives the host
// strobes and observes the W5300 side uses the master view.
interface w5300_bus_timer_if;

    // Host / decoder side
    logic wiz_sel;     // W5300 address window hit, active high
    logic asl;         // 68008 address strobe, active low
    logic dsl;         // 68008 data strobe, active low
    logic rdwl;        // 1 = read, 0 = write

    // W5300 side
    logic wizcsl;      // chip select, active low
    logic wizrdl;      // read strobe, active low
    logic wizwrl;      // write strobe, active low
    logic dtack_req;   // request to pull dtackl low
    logic busy;        // sequencer not idle

    modport slave (
        input  wiz_sel,
        input  asl,
        input  dsl,
        input  rdwl,
        output wizcsl,
        output wizrdl,
        output wizwrl,
        output dtack_req,
        output busy
    );

    modport master (
        output wiz_sel,
        output asl,
        output dsl,
        output rdwl,
        input  wizcsl,
        input  wizrdl,
        input  wizwrl,
        input  dtack_req,
        input  busy
    );

endinterface

// File: rtl/w5300_bus_timer_ds_sync.sv
// Two-flop synchroniser for an active-low host strobe. Both flops reset to 1
// so the strobe reads as negated while the card is held in reset.
module ds_sync (
    input  logic clk,
    input  logic rstl,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous strobe through two flops.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/w5300_bus_timer.sv
// Bus-cycle sequencer between the card address decoder and the W5300.
// Generates registered chip-select, read/write strobes and a DTACK request
// with fixed setup, strobe-width and recovery times, independent of how the
// host moves its data strobe.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an armed host data strobe inside the W5300 window
//   SETUP   | wizcsl low, strobes still high (address/CS setup)
//   STROBE  | wizcsl and the read or write strobe low, DTACK withheld
//   ACK     | strobes held, dtack_req high until the host negates DS
//   RECOVER | everything negated, enforce minimum wizcsl high time
module w5300_bus_timer
    import w5300_bus_pkg::*;
#(
    parameter int SETUP_CYC   = SETUP_CYC_DEF,
    parameter int STROBE_CYC  = STROBE_CYC_DEF,
    parameter int RECOVER_CYC = RECOVER_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rstl,
    w5300_bus_timer_if.slave   bus
);

    // Terminal counts: the counter starts at 0 on entry to each phase.
    localparam logic [CNT_W-1:0] SETUP_TC   = (CNT_W)'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_TC  = (CNT_W)'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_TC = (CNT_W)'(RECOVER_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic       asl_s;
    logic       dsl_s;
    logic       ds_act;

    bus_state_t       state;
    bus_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rd;
    logic             rd_nxt;
    logic             armed;
    logic             armed_nxt;

    logic wizcsl_nxt;
    logic wizrdl_nxt;
    logic wizwrl_nxt;
    logic dtack_nxt;
    logic busy_nxt;

    ds_sync u_asl_sync (
        .clk  (clk),
        .rstl (rstl),
        .d    (bus.asl),
        .q    (asl_s)
    );

    ds_sync u_dsl_sync (
        .clk  (clk),
        .rstl (rstl),
        .d    (bus.dsl),
        .q    (dsl_s)
    );

    assign ds_act = !dsl_s && !asl_s;

    // Next state, phase counter, cycle latches and next registered outputs.
    always_comb begin
        state_nxt = state;
        rd_nxt    = rd;
        armed_nxt = armed;

        case (state)
            IDLE: begin
                // wiz_sel and rdwl only matter at this instant; later changes
                // are ignored until the sequencer comes back here.
                if (ds_act && bus.wiz_sel && armed) begin
                    state_nxt = SETUP;
                    rd_nxt    = bus.rdwl;
                end
            end
            SETUP: begin
                if (!ds_act)
                    state_nxt = RECOVER;
                else if (cnt == SETUP_TC)
                    state_nxt = STROBE;
            end
            STROBE: begin
                // A host that gives up before DTACK gets no acknowledge.
                if (!ds_act)
                    state_nxt = RECOVER;
                else if (cnt == STROBE_TC)
                    state_nxt = ACK;
            end
            ACK: begin
                if (!ds_act)
                    state_nxt = RECOVER;
            end
            RECOVER: begin
                if (cnt == RECOVER_TC)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A new cycle needs DS to have been seen negated since the last one,
        // so a strobe still held from the previous host cycle cannot restart.
        if ((state == IDLE) && (state_nxt == SETUP))
            armed_nxt = 1'b0;
        else if (((state == IDLE) || (state == RECOVER)) && !ds_act)
            armed_nxt = 1'b1;

        // Phase counter restarts on every state change and saturates
        // while parked in ACK.
        if ((state_nxt != state) || (state == IDLE))
            cnt_nxt = '0;
        else if (cnt != CNT_MAX)
            cnt_nxt = cnt + 1'b1;
        else
            cnt_nxt = cnt;

        // Outputs are decoded from the next state so they change on the
        // same edge as the state register.
        wizcsl_nxt = !cs_phase(state_nxt);
        wizrdl_nxt = !(strobe_phase(state_nxt) && rd_nxt);
        wizwrl_nxt = !(strobe_phase(state_nxt) && !rd_nxt);
        dtack_nxt  = (state_nxt == ACK);
        busy_nxt   = (state_nxt != IDLE);
    end

    // State register, cycle latches and registered W5300 outputs.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state         <= IDLE;
            cnt           <= '0;
            rd            <= 1'b1;
            armed         <= 1'b0;
            bus.wizcsl    <= 1'b1;
            bus.wizrdl    <= 1'b1;
            bus.wizwrl    <= 1'b1;
            bus.dtack_req <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rd            <= rd_nxt;
            armed         <= armed_nxt;
            bus.wizcsl    <= wizcsl_nxt;
            bus.wizrdl    <= wizrdl_nxt;
            bus.wizwrl    <= wizwrl_nxt;
            bus.dtack_req <= dtack_nxt;
            bus.busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_w5300_bus_timer.sv
// Directed bench for the W5300 bus-cycle sequencer using default timing
// (SETUP 1, STROBE 3, RECOVER 2). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so "eN" below means "just after the
// N-th rising edge following the stimulus change".
module tb_w5300_bus_timer;

    logic clk;
    logic rstl;
    int   checks;
    int   failures;

    w5300_bus_timer_if bus_if ();

    w5300_bus_timer dut (
        .clk  (clk),
        .rstl (rstl),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host(input logic sel, input logic rw, input logic ds);
        bus_if.wiz_sel = sel;
        bus_if.rdwl    = rw;
        bus_if.asl     = ds;
        bus_if.dsl     = ds;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_csl"},   bus_if.wizcsl,    1'b1);
        chk({tag, "_rdl"},   bus_if.wizrdl,    1'b1);
        chk({tag, "_wrl"},   bus_if.wizwrl,    1'b1);
        chk({tag, "_dtack"}, bus_if.dtack_req, 1'b0);
        chk({tag, "_busy"},  bus_if.busy,      1'b0);
    endtask

    // Strobe exclusivity and strobes only under chip select, every cycle.
    always @(negedge clk) begin
        if (rstl === 1'b1) begin
            chk("inv_not_both", !(bus_if.wizrdl === 1'b0 && bus_if.wizwrl === 1'b0), 1'b1);
            chk("inv_strobe_cs",
                !(bus_if.wizcsl === 1'b1 && (bus_if.wizrdl === 1'b0 || bus_if.wizwrl === 1'b0)),
                1'b1);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rstl     = 1'b1;
        host(1'b0, 1'b1, 1'b1);

        // Reset values
        #2 rstl = 1'b0;
        #1;
        chk_idle("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstl = 1'b1;
        cyc(3);
        chk_idle("post_reset");

        // Read with defaults
        host(1'b1, 1'b1, 1'b0);
        cyc(1);
        chk("rd_e1_csl", bus_if.wizcsl, 1'b1);
        chk("rd_e1_busy", bus_if.busy, 1'b0);
        cyc(1);
        chk("rd_e2_csl", bus_if.wizcsl, 1'b1);
        cyc(1);
        chk("rd_e3_csl", bus_if.wizcsl, 1'b0);
        chk("rd_e3_rdl", bus_if.wizrdl, 1'b1);
        chk("rd_e3_busy", bus_if.busy, 1'b1);
        cyc(1);
        chk("rd_e4_rdl", bus_if.wizrdl, 1'b0);
        chk("rd_e4_wrl", bus_if.wizwrl, 1'b1);
        chk("rd_e4_dtack", bus_if.dtack_req, 1'b0);
        cyc(2);
        chk("rd_e6_dtack", bus_if.dtack_req, 1'b0);
        cyc(1);
        chk("rd_e7_dtack", bus_if.dtack_req, 1'b1);
        chk("rd_e7_rdl", bus_if.wizrdl, 1'b0);
        cyc(2);
        chk("rd_e9_dtack", bus_if.dtack_req, 1'b1);
        chk("rd_e9_rdl", bus_if.wizrdl, 1'b0);
        host(1'b0, 1'b1, 1'b1);
        cyc(2);
        chk("rd_rel2_dtack", bus_if.dtack_req, 1'b1);
        chk("rd_rel2_rdl", bus_if.wizrdl, 1'b0);
        cyc(1);
        chk("rd_rel3_csl", bus_if.wizcsl, 1'b1);
        chk("rd_rel3_rdl", bus_if.wizrdl, 1'b1);
        chk("rd_rel3_dtack", bus_if.dtack_req, 1'b0);
        chk("rd_rel3_busy", bus_if.busy, 1'b1);
        cyc(1);
        chk("rd_rel4_busy", bus_if.busy, 1'b1);
        cyc(1);
        chk_idle("rd_rel5");

        // Write with defaults; rdwl/wiz_sel wobble mid-cycle is ignored
        cyc(2);
        host(1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("wr_e3_csl", bus_if.wizcsl, 1'b0);
        chk("wr_e3_wrl", bus_if.wizwrl, 1'b1);
        cyc(1);
        chk("wr_e4_wrl", bus_if.wizwrl, 1'b0);
        chk("wr_e4_rdl", bus_if.wizrdl, 1'b1);
        host(1'b0, 1'b1, 1'b0);
        cyc(1);
        chk("wr_e5_wrl", bus_if.wizwrl, 1'b0);
        chk("wr_e5_rdl", bus_if.wizrdl, 1'b1);
        cyc(2);
        chk("wr_e7_dtack", bus_if.dtack_req, 1'b1);
        chk("wr_e7_wrl", bus_if.wizwrl, 1'b0);
        chk("wr_e7_rdl", bus_if.wizrdl, 1'b1);
        host(1'b0, 1'b1, 1'b1);
        cyc(2);
        chk("wr_rel2_wrl", bus_if.wizwrl, 1'b0);
        chk("wr_rel2_csl", bus_if.wizcsl, 1'b0);
        chk("wr_rel2_dtack", bus_if.dtack_req, 1'b1);
        cyc(1);
        chk("wr_rel3_wrl", bus_if.wizwrl, 1'b1);
        chk("wr_rel3_csl", bus_if.wizcsl, 1'b1);
        chk("wr_rel3_dtack", bus_if.dtack_req, 1'b0);
        cyc(2);
        chk_idle("wr_rel5");

        // Abort: DS negated right after the write strobe falls
        cyc(2);
        host(1'b1, 1'b0, 1'b0);
        cyc(4);
        chk("ab_e4_wrl", bus_if.wizwrl, 1'b0);
        host(1'b1, 1'b0, 1'b1);
        cyc(1);
        chk("ab_e5_dtack", bus_if.dtack_req, 1'b0);
        chk("ab_e5_wrl", bus_if.wizwrl, 1'b0);
        cyc(1);
        chk("ab_e6_dtack", bus_if.dtack_req, 1'b0);
        chk("ab_e6_wrl", bus_if.wizwrl, 1'b0);
        cyc(1);
        chk("ab_e7_dtack", bus_if.dtack_req, 1'b0);
        chk("ab_e7_wrl", bus_if.wizwrl, 1'b1);
        chk("ab_e7_csl", bus_if.wizcsl, 1'b1);
        chk("ab_e7_busy", bus_if.busy, 1'b1);
        cyc(1);
        chk("ab_e8_dtack", bus_if.dtack_req, 1'b0);
        chk("ab_e8_busy", bus_if.busy, 1'b1);
        cyc(1);
        chk_idle("ab_e9");

        // No select: DS low outside the W5300 window
        cyc(2);
        host(1'b0, 1'b1, 1'b0);
        cyc(3);
        chk_idle("nosel_e3");
        cyc(3);
        chk_idle("nosel_e6");
        host(1'b0, 1'b1, 1'b1);
        cyc(3);
        chk_idle("nosel_rel");

        // Back-to-back: second DS falls during RECOVER
        host(1'b1, 1'b1, 1'b0);
        cyc(7);
        chk("b2b_a_dtack", bus_if.dtack_req, 1'b1);
        host(1'b1, 1'b1, 1'b1);
        cyc(3);
        chk("b2b_rec_csl", bus_if.wizcsl, 1'b1);
        chk("b2b_rec_busy", bus_if.busy, 1'b1);
        host(1'b1, 1'b1, 1'b0);
        cyc(1);
        chk("b2b_n4_csl", bus_if.wizcsl, 1'b1);
        cyc(1);
        chk("b2b_n5_csl", bus_if.wizcsl, 1'b1);
        chk("b2b_n5_busy", bus_if.busy, 1'b0);
        cyc(1);
        chk("b2b_n6_csl", bus_if.wizcsl, 1'b0);
        chk("b2b_n6_busy", bus_if.busy, 1'b1);
        cyc(4);
        chk("b2b_b_dtack", bus_if.dtack_req, 1'b1);
        chk("b2b_b_rdl", bus_if.wizrdl, 1'b0);
        // One-cycle DS blip: ends the cycle but never seen negated in RECOVER
        host(1'b1, 1'b1, 1'b1);
        cyc(1);
        host(1'b1, 1'b1, 1'b0);
        cyc(1);
        chk("b2b_m2_dtack", bus_if.dtack_req, 1'b1);
        cyc(1);
        chk("b2b_m3_dtack", bus_if.dtack_req, 1'b0);
        chk("b2b_m3_csl", bus_if.wizcsl, 1'b1);
        chk("b2b_m3_busy", bus_if.busy, 1'b1);
        cyc(2);
        chk_idle("b2b_m5");
        cyc(5);
        chk_idle("b2b_held");
        host(1'b0, 1'b1, 1'b1);
        cyc(3);
        chk_idle("b2b_rel");

        // Reset asserted mid-STROBE
        host(1'b1, 1'b1, 1'b0);
        cyc(5);
        chk("rst_e5_rdl", bus_if.wizrdl, 1'b0);
        #2 rstl = 1'b0;
        #1;
        chk_idle("rst_mid");
        host(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rstl = 1'b1;
        cyc(3);
        chk_idle("rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
